// File: rtl/seq_multiplier_param_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Provides the FSM state enum, counter sizing and the sign/zero extension used by the step adder.
package mult_pkg;

   localparam int MAX_W = 32;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   // Extend the low w bits of v to MAX_W+1 bits; the caller truncates to WIDTH+1.
   function automatic logic [MAX_W:0] ext_op(input logic [MAX_W-1:0] v, input int w,
                                             input logic mode);
      logic [MAX_W:0] r;
      r = '0;
      for (int i = 0; i <= MAX_W; i++)
         r[i] = (i < w) ? v[i] : (mode & v[w-1]);
      return r;
   endfunction

endpackage

// File: rtl/seq_multiplier_param_if.sv
// Operand / result bundle for seq_multiplier_param.
// The master side drives operands and start; the slave side returns product and status.
interface seq_multiplier_param_if #(parameter int WIDTH = 8);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic [2*WIDTH-1:0]   Product;
   logic                 ready;
   logic                 busy;
   logic                 done;

   modport master (output start, signed_mode, A, B,
                   input  Product, ready, busy, done);
   modport slave  (input  start, signed_mode, A, B,
                   output Product, ready, busy, done);
endinterface

// File: rtl/seq_multiplier_param_addsub.sv
// One partial-product step: hi + (0 | M | -M) at WIDTH+1 bits, carry discarded.
// The negated multiplicand applies the -2^(W-1) weight of a signed multiplier MSB.
module mult_step_addsub
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_m,
   input  logic             i_p0,
   input  logic             i_mode,
   input  logic             i_last,
   output logic [WIDTH:0]   o_sum
);

   logic [WIDTH:0] w_hi_ext;
   logic [WIDTH:0] w_m_ext;
   logic [WIDTH:0] w_addend;

   assign w_hi_ext = (WIDTH+1)'(ext_op(MAX_W'(i_hi), WIDTH, i_mode));
   assign w_m_ext  = (WIDTH+1)'(ext_op(MAX_W'(i_m),  WIDTH, i_mode));

   always_comb begin
      w_addend = '0;
      if (i_p0)
         w_addend = (i_last && i_mode) ? (~w_m_ext + 1'b1) : w_m_ext;
   end

   assign o_sum = w_hi_ext + w_addend;

endmodule

// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier, one partial product per clock, signed or unsigned.
// Product doubles as the multiplier shift register: low half holds remaining B bits.
module seq_multiplier_param
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic                     clk,
   input  logic                     rst,
   seq_multiplier_param_if.slave    bus
);

   localparam int CW = cnt_width(WIDTH);

   state_e               r_state;
   state_e               w_next;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_m;
   logic                 r_mode;
   logic [2*WIDTH-1:0]   r_prod;
   logic                 r_done;
   logic                 w_last;
   logic [WIDTH:0]       w_sum;

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   mult_step_addsub #(.WIDTH(WIDTH)) u_step (
      .i_hi   (r_prod[2*WIDTH-1:WIDTH]),
      .i_m    (r_m),
      .i_p0   (r_prod[0]),
      .i_mode (r_mode),
      .i_last (w_last),
      .o_sum  (w_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // start wins over step completion, so a restart on the last step aborts cleanly
   always_comb begin
      w_next = r_state;
      if (bus.start)
         w_next = RUN;
      else if (r_state == RUN && w_last)
         w_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_m    <= '0;
         r_mode <= 1'b0;
         r_prod <= '0;
         r_done <= 1'b0;
      end else if (bus.start) begin
         r_cnt  <= '0;
         r_m    <= bus.A;
         r_mode <= bus.signed_mode;
         r_prod <= {{WIDTH{1'b0}}, bus.B};
         r_done <= 1'b0;
      end else if (r_state == RUN) begin
         r_cnt  <= r_cnt + 1'b1;
         r_prod <= {w_sum, r_prod[WIDTH-1:1]};
         r_done <= w_last;
      end else begin
         r_done <= 1'b0;
      end
   end

   assign bus.Product = r_prod;
   assign bus.ready   = (r_state == IDLE);
   assign bus.busy    = (r_state == RUN);
   assign bus.done    = r_done;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed and randomized checks of seq_multiplier_param at WIDTH=8 and WIDTH=16.
module tb_seq_multiplier_param;
   import mult_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   seq_multiplier_param_if #(.WIDTH(8))  bus8 ();
   seq_multiplier_param_if #(.WIDTH(16)) bus16 ();

   seq_multiplier_param #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
   seq_multiplier_param #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic run8(input string tag, input logic mode, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp);
      int cyc, dn;
      @(negedge clk);
      bus8.start = 1'b1; bus8.signed_mode = mode; bus8.A = a; bus8.B = b;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      bus8.A = 8'($urandom); bus8.B = 8'($urandom); bus8.signed_mode = ~mode;
      chk({tag, "_busy"}, 64'(bus8.busy), 64'd1);
      cyc = 0; dn = 0;
      while (!bus8.ready && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         dn += int'(bus8.done);
      end
      chk({tag, "_lat"}, 64'(cyc), 64'd8);
      chk({tag, "_prod"}, 64'(bus8.Product), 64'(exp));
      chk({tag, "_done"}, 64'(dn), 64'd1);
      @(posedge clk); #1;
      chk({tag, "_dclr"}, 64'(bus8.done), 64'd0);
      chk({tag, "_hold"}, 64'(bus8.Product), 64'(exp));
   endtask

   task automatic run16(input string tag, input logic mode, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp);
      int cyc, dn;
      @(negedge clk);
      bus16.start = 1'b1; bus16.signed_mode = mode; bus16.A = a; bus16.B = b;
      @(posedge clk); #1;
      bus16.start = 1'b0;
      cyc = 0; dn = 0;
      while (!bus16.ready && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         dn += int'(bus16.done);
      end
      chk({tag, "_lat"}, 64'(cyc), 64'd16);
      chk({tag, "_prod"}, 64'(bus16.Product), 64'(exp));
      chk({tag, "_done"}, 64'(dn), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn, cyc;
      logic [7:0]  ra, rb;
      logic        rm;
      logic [15:0] rexp;

      bus8.start = 0;  bus8.signed_mode = 0;  bus8.A = 0;  bus8.B = 0;
      bus16.start = 0; bus16.signed_mode = 0; bus16.A = 0; bus16.B = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_prod",  64'(bus8.Product), 64'd0);
      chk("rst_ready", 64'(bus8.ready),   64'd1);
      chk("rst_busy",  64'(bus8.busy),    64'd0);
      chk("rst_done",  64'(bus8.done),    64'd0);
      chk("rst_prod16", 64'(bus16.Product), 64'd0);

      run8("s_m3x5",    1'b1, 8'hFD, 8'h05, 16'hFFF1);
      run8("u_ffxff",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
      run8("s_ffxff",   1'b1, 8'hFF, 8'hFF, 16'h0001);
      run8("s_80x80",   1'b1, 8'h80, 8'h80, 16'h4000);
      run8("s_80x7f",   1'b1, 8'h80, 8'h7F, 16'hC080);
      run8("u_80x80",   1'b0, 8'h80, 8'h80, 16'h4000);
      run8("s_7fx80",   1'b1, 8'h7F, 8'h80, 16'hC080);
      run8("u_0x5a",    1'b0, 8'h00, 8'h5A, 16'h0000);

      // abort: second start three cycles after the first
      @(negedge clk);
      bus8.start = 1; bus8.signed_mode = 0; bus8.A = 8'd3; bus8.B = 8'd4;
      @(posedge clk); #1;
      bus8.start = 0;
      dn = 0;
      repeat (2) begin @(posedge clk); #1; dn += int'(bus8.done); end
      bus8.start = 1; bus8.A = 8'h07; bus8.B = 8'h09;
      @(posedge clk); #1;
      bus8.start = 0;
      chk("abort_ready", 64'(bus8.ready), 64'd0);
      cyc = 0;
      while (!bus8.ready && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         dn += int'(bus8.done);
      end
      chk("abort_lat",  64'(cyc), 64'd8);
      chk("abort_prod", 64'(bus8.Product), 64'h003F);
      chk("abort_done", 64'(dn), 64'd1);

      // reset in the middle of a run
      @(negedge clk);
      bus8.start = 1; bus8.A = 8'd5; bus8.B = 8'd5;
      @(posedge clk); #1;
      bus8.start = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("midrst_prod",  64'(bus8.Product), 64'd0);
      chk("midrst_ready", 64'(bus8.ready),   64'd1);
      chk("midrst_done",  64'(bus8.done),    64'd0);

      // rst and start together: reset wins, nothing starts
      run8("pre_rs", 1'b0, 8'h12, 8'h10, 16'h0120);
      bus8.start = 1; bus8.A = 8'h09; bus8.B = 8'h09; rst = 1;
      @(posedge clk); #1;
      bus8.start = 0; rst = 0;
      chk("rs_prod",  64'(bus8.Product), 64'd0);
      chk("rs_ready", 64'(bus8.ready),   64'd1);
      @(posedge clk); #1;
      chk("rs_idle",  64'(bus8.busy),    64'd0);

      run16("u16_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      run16("s16_8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
      run16("s16_m1x7", 1'b1, 16'hFFFF, 16'h0007, 32'hFFFFFFF9);

      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rm = 1'($urandom);
         if (rm) rexp = 16'(int'($signed(ra)) * int'($signed(rb)));
         else    rexp = 16'(int'(ra) * int'(rb));
         run8($sformatf("rnd%0d", i), rm, ra, rb, rexp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_multiplier_param.md
Name: seq_multiplier_param

Overview:
- Parametrised sequential shift-add multiplier: WIDTH x WIDTH operands, 2*WIDTH product, one partial-product step per clock.
- Runtime selectable signed (two's complement) or unsigned mode.
- Adds synchronous reset, a one-cycle done pulse and a busy flag.
- Sits in the lab datapath wherever a multi-cycle multiply is acceptable in exchange for low area.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sampled each edge; loads operands and begins a multiply.
- signed_mode  input  1  sampled with start; 1 = two's complement, 0 = unsigned.
- A  input  WIDTH  multiplicand, sampled with start.
- B  input  WIDTH  multiplier, sampled with start.
- Product  output  2*WIDTH  result register; valid while ready=1 after a completed operation.
- ready  output  1  high when idle or finished.
- busy  output  1  equal to ~ready.
- done  output  1  one-cycle pulse on the cycle ready rises after a RUN.

Behaviour:
- Reset (rst=1 at edge): Product=0, ready=1, busy=0, done=0, counter=0, internal multiplicand=0, mode=0.
- rst has priority over start in the same cycle.
- States: IDLE (ready=1) and RUN (ready=0).
- Load: start=1 at an edge, in either state, loads the registers as follows:
  - multiplicand register M<=A; mode<=signed_mode; counter<=0.
  - Product<={WIDTH zeros, B}.
  - ready<=0, done<=0; next state RUN.
- start during RUN aborts the current operation and restarts with the new operands. No partial result is reported and done does not pulse for the aborted operation.
- RUN step (each edge with start=0), with k=counter, k=0..WIDTH-1:
  - hi = Product[2W-1:W], extended to WIDTH+1 bits: sign-extended if mode=1, zero-extended if mode=0.
  - addend = 0 if Product[0]=0.
  - Otherwise addend = M extended to WIDTH+1 bits (same extension rule).
  - Exception: on the last step (k=WIDTH-1) with mode=1, addend is the two's-complement negation of sign-extended M. This applies the weight -2^(W-1) of the multiplier MSB.
  - sum = hi + addend, WIDTH+1 bits, carry out discarded.
  - Product <= {sum, Product[W-1:1]}; counter<=counter+1.
- Completion:
  - The edge performing step k=WIDTH-1 also sets ready<=1 and done<=1; next state IDLE.
  - done clears on the following edge.
- Latency: start sampled at edge N; result, ready and done are visible after edge N+WIDTH. Exactly WIDTH RUN cycles.
- IDLE holds Product, M and mode unchanged until the next start or rst.
- Operand inputs are ignored except on the start edge.
- Arithmetic must be exact for all operand pairs, including:
  - Signed: -2^(W-1) x -2^(W-1) = +2^(2W-2).
  - Unsigned: (2^W-1)^2.
- M is never modified in place; negation is combinational on the last step only.
- Counter width $clog2(WIDTH+1); no wrap occurs, since RUN exits at WIDTH steps.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, RUN}.
  - function for the WIDTH+1 extension (sign/zero selectable by mode).
  - localparam counter width.
- One natural sub-module: mult_step_addsub. Purely combinational WIDTH+1 adder/negator producing sum from hi, M, Product[0], mode and last-step flag.
- The top level holds the FSM, counter and registers.

Test Plan:
- WIDTH=8, signed_mode=1, A=8'hFD (-3), B=8'h05 -> after 8 cycles Product=16'hFFF1, ready=1, done pulses exactly once.
- WIDTH=8, signed_mode=0, A=8'hFF, B=8'hFF -> Product=16'hFE01; the same operands with signed_mode=1 -> Product=16'h0001.
- WIDTH=8, signed: A=8'h80, B=8'h80 -> 16'h4000; A=8'h80, B=8'h7F -> 16'hC080.
- Abort/restart: start A=3,B=4; at cycle 3 start A=8'h07,B=8'h09 unsigned -> ready stays low, 8 cycles after the second start Product=16'h003F, a single done pulse. Then rst mid-RUN -> next cycle Product=0, ready=1, done=0.
- rst and start high together -> reset state, no operation begins. WIDTH=16 build, unsigned 16'hFFFF x 16'hFFFF -> 32'hFFFE0001 after 16 cycles.
- Random self-check, WIDTH=8 and 13, both modes, 10k vectors against a reference product -> zero mismatches, latency always WIDTH.
